// File: rtl/soft_reset_pkg.sv
// rtl/soft_reset_pkg.sv - shared state encoding and default timing constants for soft_reset_gen
package soft_reset_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_ASSERT   = 2'd2,
        ST_HOLDOFF  = 2'd3
    } state_e;

    localparam int CNT_W                  = 8;
    localparam int DEF_DEBOUNCE_CYCLES    = 16;
    localparam int DEF_PULSE_CYCLES       = 8;
    localparam int DEF_HOLDOFF_CYCLES     = 32;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input bit
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/soft_reset_gen.sv
// rtl/soft_reset_gen.sv - debounced button / request driven soft reset pulse generator
module soft_reset_gen
    import soft_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic btn_in,
    input  logic req_in,
    output logic ack_out,
    output logic soft_rst_n,
    output logic busy
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
        PULSE_CYCLES < 1 || PULSE_CYCLES > 255 ||
        HOLDOFF_CYCLES < 1 || HOLDOFF_CYCLES > 255) begin : g_bad_param
        $error("soft_reset_gen: cycle parameter outside 8-bit counter range");
    end

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             srn_q, srn_d;
    logic             btn_s;

    sync_2ff u_btn_sync (
        .clk_i (clk_in),
        .rst_n (rst_n),
        .d_i   (btn_in),
        .q_o   (btn_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A request beats a simultaneous press; HOLDOFF absorbs the press later.
                if (req_in) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                end else if (btn_s) begin
                    state_d = ST_DEBOUNCE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ASSERT: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = ST_HOLDOFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (btn_s) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Output flop follows the next state so the pulse starts on the entering edge.
        srn_d = (state_d != ST_ASSERT);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            srn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            srn_q   <= srn_d;
        end
    end

    assign ack_out    = ack_q;
    assign soft_rst_n = srn_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_soft_reset_gen.sv
// tb/tb_soft_reset_gen.sv - self-checking bench for soft_reset_gen against a behavioural model
module tb_soft_reset_gen;

    localparam int DEB  = 4;
    localparam int PUL  = 3;
    localparam int HOLD = 5;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    logic btn_in = 1'b0;
    logic req_in = 1'b0;
    logic ack_out;
    logic soft_rst_n;
    logic busy;

    int n_vec = 0;
    int n_bad = 0;

    soft_reset_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .PULSE_CYCLES    (PUL),
        .HOLDOFF_CYCLES  (HOLD)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .btn_in     (btn_in),
        .req_in     (req_in),
        .ack_out    (ack_out),
        .soft_rst_n (soft_rst_n),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    // Behavioural model: mode 0 idle, 1 pressing, 2 pulsing, 3 waiting for release.
    int   m_mode;
    int   press_run;
    int   pulse_left;
    int   release_run;
    logic m_s1, m_s2;
    logic exp_ack, exp_srn;

    int low_cnt, ack_cnt, busy_cnt;

    task automatic model_reset();
        m_mode = 0; press_run = 0; pulse_left = 0; release_run = 0;
        m_s1 = 1'b0; m_s2 = 1'b0;
        exp_ack = 1'b0; exp_srn = 1'b0;
    endtask

    task automatic model_edge(input logic b, input logic r);
        logic bs;
        bs = m_s2;
        m_s2 = m_s1;
        m_s1 = b;
        exp_ack = 1'b0;
        case (m_mode)
            0: begin
                if (r) begin
                    m_mode = 2; pulse_left = PUL; exp_ack = 1'b1;
                end else if (bs) begin
                    m_mode = 1; press_run = 1;
                end
            end
            1: begin
                if (!bs) m_mode = 0;
                else if (press_run == DEB - 1) begin
                    m_mode = 2; pulse_left = PUL;
                end else press_run++;
            end
            2: begin
                pulse_left--;
                if (pulse_left == 0) begin
                    m_mode = 3; release_run = 0;
                end
            end
            default: begin
                if (bs) release_run = 0;
                else begin
                    release_run++;
                    if (release_run == HOLD) m_mode = 0;
                end
            end
        endcase
        exp_srn = (m_mode != 2);
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs == exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_ack"},  ack_out,    exp_ack);
        check({tag, "_srn"},  soft_rst_n, exp_srn);
        check({tag, "_busy"}, busy,       logic'(m_mode != 0));
    endtask

    task automatic cycle(input logic b, input logic r, input string tag);
        btn_in = b;
        req_in = r;
        @(posedge clk_in);
        model_edge(b, r);
        #1;
        check_all(tag);
        if (soft_rst_n === 1'b0) low_cnt++;
        if (ack_out === 1'b1) ack_cnt++;
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, tag);
    endtask

    task automatic pulse_reset(input int n);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
            check_all("rst_hold");
        end
        rst_n = 1'b1;
    endtask

    task automatic clear_counts();
        low_cnt = 0; ack_cnt = 0; busy_cnt = 0;
    endtask

    initial begin
        logic b_rand;
        model_reset();
        clear_counts();

        // Reset state, then release with and without a pending request.
        #2;
        check_all("reset");
        pulse_reset(2);
        cycle(1'b0, 1'b0, "post_rst");
        pulse_reset(1);
        cycle(1'b0, 1'b1, "post_rst_req");
        idle_cycles(12, "drain0");

        // Long clean press.
        clear_counts();
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, "press_hold");
        idle_cycles(12, "press_rel");
        check_cnt("press_low_cycles", low_cnt, PUL);
        check_cnt("press_ack_cycles", ack_cnt, 0);

        // Bouncy press never reaches the debounce threshold.
        clear_counts();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "bounce_hi");
            cycle(1'b0, 1'b0, "bounce_lo");
        end
        idle_cycles(4, "bounce_end");
        check_cnt("bounce_low_cycles", low_cnt, 0);

        // Single request.
        clear_counts();
        cycle(1'b0, 1'b1, "req");
        idle_cycles(12, "req_drain");
        check_cnt("req_low_cycles", low_cnt, PUL);
        check_cnt("req_ack_cycles", ack_cnt, 1);
        check_cnt("req_busy_cycles", busy_cnt, PUL + HOLD);

        // Requests during pulse and holdoff are dropped.
        clear_counts();
        cycle(1'b0, 1'b1, "req2");
        cycle(1'b0, 1'b1, "req2_in_pulse");
        cycle(1'b0, 1'b0, "req2_gap");
        cycle(1'b0, 1'b0, "req2_gap");
        cycle(1'b0, 1'b1, "req2_in_hold");
        cycle(1'b0, 1'b1, "req2_in_hold");
        idle_cycles(10, "req2_drain");
        check_cnt("ignore_low_cycles", low_cnt, PUL);
        check_cnt("ignore_ack_cycles", ack_cnt, 1);

        // Button held through the pulse, holdoff waits for release.
        clear_counts();
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, "held");
        cycle(1'b0, 1'b0, "held_rel");
        cycle(1'b1, 1'b0, "held_blip");
        idle_cycles(12, "held_drain");
        check_cnt("held_low_cycles", low_cnt, PUL);

        // Reset in the middle of a pulse.
        clear_counts();
        cycle(1'b0, 1'b1, "abort_req");
        cycle(1'b0, 1'b0, "abort_pulse2");
        pulse_reset(2);
        clear_counts();
        cycle(1'b0, 1'b0, "abort_release");
        idle_cycles(10, "abort_drain");
        check_cnt("abort_low_cycles", low_cnt, 0);

        // Reset mid-debounce.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, "abort_deb");
        pulse_reset(1);
        idle_cycles(10, "abort_deb_drain");

        // Randomized traffic with run-length button noise and rare resets.
        b_rand = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) b_rand = ~b_rand;
            if ($urandom_range(0, 199) == 0) pulse_reset($urandom_range(0, 2));
            else cycle(b_rand, logic'($urandom_range(0, 19) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
